// File: rtl/muldiv_seq_64.sv
// muldiv_seq_64: iterative 64-bit unsigned MUL/MULHU/DIVU/REMU, one bit per cycle.
// Shift-add multiply and restoring divide share one accumulator / shift register pair.
module muldiv_seq_64 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  MulDivOp,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] Result,
  output logic        done,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [5:0]  cnt_r;
  logic [1:0]  op_r;
  logic [63:0] a_r;
  logic [63:0] b_r;
  logic [63:0] acc_r;     // product high half, or partial remainder
  logic [63:0] lo_r;      // product low half / multiplier, or quotient / dividend
  logic [63:0] result_r;
  logic [64:0] add_s;
  logic [64:0] shl_s;
  logic [63:0] acc_nxt_s;
  logic [63:0] lo_nxt_s;
  logic [63:0] fin_s;
  logic        div_zero_s;
  logic        busy_s;
  logic        done_s;

  assign div_zero_s = MulDivOp[1] & (b == 64'd0);
  assign Result     = result_r;
  assign busy       = busy_s;
  assign done       = done_s;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; divide by zero skips the iteration phase entirely
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (div_zero_s) begin
            state_s = DONE;
          end else begin
            state_s = BUSY;
          end
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == 6'd0) begin
          state_s = DONE;
        end else begin
          state_s = BUSY;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Status outputs decoded from the state register
  always_comb begin
    busy_s = (state_r != IDLE);
    done_s = (state_r == DONE);
  end

  // One iteration of either shift-add multiply or restoring divide
  always_comb begin
    add_s = {1'b0, acc_r} + (lo_r[0] ? {1'b0, a_r} : 65'd0);
    shl_s = {acc_r, lo_r[63]};
    if (op_r[1]) begin
      // The remainder stays below b, so the 64-bit subtraction cannot lose bits
      if (shl_s >= {1'b0, b_r}) begin
        acc_nxt_s = shl_s[63:0] - b_r;
        lo_nxt_s  = {lo_r[62:0], 1'b1};
      end else begin
        acc_nxt_s = shl_s[63:0];
        lo_nxt_s  = {lo_r[62:0], 1'b0};
      end
    end else begin
      acc_nxt_s = add_s[64:1];
      lo_nxt_s  = {add_s[0], lo_r[63:1]};
    end
    case (op_r)
      2'b00:   fin_s = lo_nxt_s;
      2'b01:   fin_s = acc_nxt_s;
      2'b10:   fin_s = lo_nxt_s;
      2'b11:   fin_s = acc_nxt_s;
      default: fin_s = lo_nxt_s;
    endcase
  end

  // Operand capture, iteration datapath and result register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r    <= 6'd0;
      op_r     <= 2'd0;
      a_r      <= 64'd0;
      b_r      <= 64'd0;
      acc_r    <= 64'd0;
      lo_r     <= 64'd0;
      result_r <= 64'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            op_r  <= MulDivOp;
            a_r   <= a;
            b_r   <= b;
            cnt_r <= 6'd63;
            acc_r <= 64'd0;
            lo_r  <= MulDivOp[1] ? a : b;
            if (div_zero_s) begin
              result_r <= MulDivOp[0] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
            end else begin
              result_r <= result_r;
            end
          end else begin
            cnt_r <= cnt_r;
          end
        end
        BUSY: begin
          cnt_r <= cnt_r - 6'd1;
          acc_r <= acc_nxt_s;
          lo_r  <= lo_nxt_s;
          if (cnt_r == 6'd0) begin
            result_r <= fin_s;
          end else begin
            result_r <= result_r;
          end
        end
        default: begin
          result_r <= result_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq_64.sv
// Directed bench for muldiv_seq_64: vector table for the four operations plus
// hand-written sequences for start-while-busy and reset-abort.
module tb_muldiv_seq_64;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  MulDivOp;
  logic [63:0] a;
  logic [63:0] b;
  logic [63:0] Result;
  logic        done;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_seq_64 dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .MulDivOp (MulDivOp),
    .a        (a),
    .b        (b),
    .Result   (Result),
    .done     (done),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [63:0] av;
    logic [63:0] bv;
    logic [63:0] res;
    int          lat;   // edges after the accepting edge until done is seen
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one operation, scramble the inputs after acceptance, then track busy/done.
  task automatic run_vec(input int idx, input logic [1:0] op, input logic [63:0] av,
                         input logic [63:0] bv, input logic [63:0] exp_res, input int exp_lat);
    int lat = -1;
    int done_cnt = 0;
    int busy_cnt = 0;
    logic [63:0] res_at_done = 64'd0;
    logic fell = 1'b0;
    @(negedge clk);
    start = 1'b1; MulDivOp = op; a = av; b = bv;
    @(posedge clk);
    #1;
    start = 1'b0; MulDivOp = ~op; a = ~av; b = bv ^ 64'h5555_0000_AAAA_0001;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (lat < 0) begin
          lat = n;
          res_at_done = Result;
        end
      end
      if (busy) busy_cnt++;
      else begin
        fell = 1'b1;
        break;
      end
    end
    chk($sformatf("v%0d busy_fell", idx), {63'd0, fell}, 64'd1);
    chk($sformatf("v%0d done_latency", idx), 64'(lat), 64'(exp_lat));
    chk($sformatf("v%0d done_pulses", idx), 64'(done_cnt), 64'd1);
    chk($sformatf("v%0d busy_cycles", idx), 64'(busy_cnt), 64'(exp_lat + 1));
    chk($sformatf("v%0d result", idx), res_at_done, exp_res);
    chk($sformatf("v%0d result_held", idx), Result, exp_res);
  endtask

  initial begin
    int done_cnt;
    logic fell;

    vecs[0]  = '{2'b00, 64'd3, 64'd5, 64'd15, 64};
    vecs[1]  = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 64};
    vecs[2]  = '{2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64};
    vecs[3]  = '{2'b10, 64'd100, 64'd7, 64'd14, 64};
    vecs[4]  = '{2'b11, 64'd100, 64'd7, 64'd2, 64};
    vecs[5]  = '{2'b10, 64'h8000_0000_0000_0000, 64'd1, 64'h8000_0000_0000_0000, 64};
    vecs[6]  = '{2'b10, 64'd42, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0};
    vecs[7]  = '{2'b11, 64'd42, 64'd0, 64'd42, 0};
    vecs[8]  = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64};
    vecs[9]  = '{2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64};
    vecs[10] = '{2'b01, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 64'd1, 64};
    vecs[11] = '{2'b11, 64'd5, 64'd9, 64'd5, 64};

    reset = 1'b1; start = 1'b0; MulDivOp = 2'b00; a = 64'd0; b = 64'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_result", Result, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_vec(i, vecs[i].op, vecs[i].av, vecs[i].bv, vecs[i].res, vecs[i].lat);
    end

    // Start held high from iteration 20 through the done cycle must be ignored
    @(negedge clk);
    start = 1'b1; MulDivOp = 2'b10; a = 64'd100; b = 64'd7;
    @(posedge clk);
    #1 start = 1'b0;
    done_cnt = 0;
    fell = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (n == 20) begin
        start = 1'b1; MulDivOp = 2'b00; a = 64'd3; b = 64'd5;
      end
      if (done) begin
        done_cnt++;
        chk("busy_start_result", Result, 64'd14);
      end
      if (!busy) begin
        fell = 1'b1;
        start = 1'b0;
        break;
      end
    end
    chk("busy_start_fell", {63'd0, fell}, 64'd1);
    chk("busy_start_pulses", 64'(done_cnt), 64'd1);
    @(negedge clk);
    chk("busy_start_not_accepted", {63'd0, busy}, 64'd0);
    chk("busy_start_result_held", Result, 64'd14);

    // Reset during iteration 30 aborts with no done
    @(negedge clk);
    start = 1'b1; MulDivOp = 2'b00; a = 64'd6; b = 64'd7;
    @(posedge clk);
    #1 start = 1'b0;
    done_cnt = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_result", Result, 64'd0);
    for (int n = 0; n < 70; n++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    run_vec(99, 2'b00, 64'd6, 64'd7, 64'd42, 64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
